// File: rtl/halfband_ts_mac_ctrl.sv
// Time-shared single-multiplier MAC for the 7-tap halfband filter: three folded
// taps are sequenced through one 18x18 multiplier per input sample.
module halfband_ts_mac_ctrl #(
  parameter logic signed [17:0] H0 = -18'sd4244,
  parameter logic signed [17:0] H2 = 18'sd36976,
  parameter logic signed [17:0] H3 = 18'sd65472
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               sam_clk_en,
  input  logic signed [17:0] x_in,
  output logic signed [17:0] y,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC1 = 3'd1;
  localparam logic [2:0] S_MAC2 = 3'd2;
  localparam logic [2:0] S_MAC3 = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic signed [17:0] x_dl [7];
  logic signed [19:0] acc;
  logic signed [17:0] pre_add;
  logic signed [17:0] coef;
  logic signed [35:0] product;
  logic signed [17:0] term;
  logic               accept;
  logic               mac_phase;
  logic               unused_bits;

  function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
    if (v > 20'sd131071)       return 18'h1FFFF;
    else if (v < -20'sd131072) return 18'h20000;
    else                       return v[17:0];
  endfunction

  assign mac_phase = (state == S_MAC1) || (state == S_MAC2) || (state == S_MAC3);
  assign accept    = sam_clk_en && ((state == S_IDLE) || (state == S_DONE));

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pre_add = '0;
    coef    = '0;
    case (state)
      S_MAC1: begin
        pre_add = x_dl[0] + x_dl[6];
        coef    = H0;
      end
      S_MAC2: begin
        pre_add = x_dl[2] + x_dl[4];
        coef    = H2;
      end
      S_MAC3: begin
        pre_add = x_dl[3];
        coef    = H3;
      end
      default: ;
    endcase
  end

  // Pre-halved samples keep the 18-bit pre-add in range; the term is the
  // floor-truncated product scaled back to 1s17.
  assign product     = pre_add * coef;
  assign term        = product[34:17];
  assign unused_bits = ^{product[35], product[16:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state <= accept ? S_MAC1 : S_IDLE;
        S_MAC1:  state <= S_MAC2;
        S_MAC2:  state <= S_MAC3;
        S_MAC3:  state <= S_DONE;
        S_DONE:  state <= accept ? S_MAC1 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the delay line is a handful of registers rather than a RAM, so it is reset like any other state.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) x_dl[i] <= '0;
    end else if (accept) begin
      x_dl[0] <= {x_in[17], x_in[17:1]};
      for (int i = 1; i < 7; i++) x_dl[i] <= x_dl[i-1];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (accept)         acc <= '0;
      else if (mac_phase) acc <= acc + {{2{term[17]}}, term};
      if (state == S_DONE) y <= sat18(acc);
    end
  end

  assign y_valid = (state == S_DONE);
  assign busy    = (state != S_IDLE);
  assign overrun = sam_clk_en && mac_phase;

endmodule

// File: tb/tb_halfband_ts_mac_ctrl.sv
// Scoreboard bench: a default-coefficient instance and a saturating-coefficient
// instance share stimulus; a reference model predicts each output sample.
module tb_halfband_ts_mac_ctrl;

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  logic               sys_clk = 1'b0;
  logic               reset_n;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y0, y1;
  logic               yv0, yv1, b0, b1, o0, o1;

  exp_t q0[$];
  exp_t q1[$];
  int   dl[7];
  int   coefs[2][3] = '{'{-4244, 36976, 65472}, '{0, 131071, 131071}};
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   vprev[2] = '{1'b0, 1'b0};

  always #5 sys_clk = ~sys_clk;

  halfband_ts_mac_ctrl dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .x_in(x_in),
    .y(y0), .y_valid(yv0), .busy(b0), .overrun(o0)
  );

  halfband_ts_mac_ctrl #(.H0(18'sd0), .H2(18'sd131071), .H3(18'sd131071)) dut_sat (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .x_in(x_in),
    .y(y1), .y_valid(yv1), .busy(b1), .overrun(o1)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: floor-scaled products of the folded taps, summed, then clamped.
  function automatic int model_y(input int k);
    int     ops[3];
    longint acc;
    ops[0] = dl[0] + dl[6];
    ops[1] = dl[2] + dl[4];
    ops[2] = dl[3];
    acc = 0;
    for (int j = 0; j < 3; j++) acc += (longint'(coefs[k][j]) * ops[j]) >>> 17;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  task automatic monitor(input int k, input int yv_now, input int y_now);
    exp_t e;
    if (vprev[k]) begin
      if ((k == 0 ? q0.size() : q1.size()) == 0) begin
        check($sformatf("unexpected_valid%0d", k), 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("y%0d", k), y_now, e.y);
        check($sformatf("latency%0d", k), cyc, e.cyc);
      end
    end
    vprev[k] = (yv_now != 0);
  endtask

  always @(negedge sys_clk) begin
    monitor(0, int'(yv0), int'(y0));
    monitor(1, int'(yv1), int'(y1));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // mode 0: accepted from IDLE, 1: accepted back-to-back in DONE, 2: dropped.
  task automatic strobe_in(input int x, input int mode);
    exp_t e;
    if (mode == 1) check("busy_b2b", int'(b0), 1);
    sam_clk_en = 1'b1;
    x_in = x[17:0];
    #1;
    if (mode == 2) begin
      check("overrun", int'(o0), 1);
      check("overrun_sat", int'(o1), 1);
    end else begin
      check("no_overrun", int'(o0), 0);
      for (int i = 6; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = x >>> 1;
      e.cyc = cyc + 5;
      e.y = model_y(0);
      q0.push_back(e);
      e.y = model_y(1);
      q1.push_back(e);
    end
    @(negedge sys_clk);
    sam_clk_en = 1'b0;
    if (mode == 2) begin
      #1;
      check("overrun_pulse_len", int'(o0), 0);
    end
  endtask

  task automatic run_b2b(input int x, input int n);
    strobe_in(x, 0);
    idle(3);
    for (int i = 1; i < n; i++) begin
      strobe_in(x, 1);
      idle(3);
    end
    idle(4);
  endtask

  initial begin
    reset_n    = 1'b0;
    sam_clk_en = 1'b0;
    x_in       = '0;
    for (int i = 0; i < 7; i++) dl[i] = 0;
    idle(3);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst_y", int'(y0), 0);
      check("rst_valid", int'(yv0), 0);
      check("rst_busy", int'(b0), 0);
      check("rst_overrun", int'(o0), 0);
    end

    // Impulse response, one strobe every 8 cycles.
    strobe_in(65536, 0);
    idle(7);
    for (int i = 0; i < 7; i++) begin
      strobe_in(0, 0);
      idle(7);
    end

    // A strobe two cycles after an accepted one is dropped.
    strobe_in(65536, 0);
    idle(1);
    strobe_in(0, 2);
    idle(4);
    for (int i = 0; i < 7; i++) begin
      strobe_in(0, 0);
      idle(7);
    end

    // DC input at the minimum strobe period.
    run_b2b(65536, 12);
    check("dc_level", int'(y0), 32734);

    // Reset while the sample is in MAC2 aborts it.
    strobe_in(65536, 0);
    idle(1);
    reset_n = 1'b0;
    #1;
    check("midrst_y", int'(y0), 0);
    check("midrst_valid", int'(yv0), 0);
    check("midrst_busy", int'(b0), 0);
    check("midrst_y_sat", int'(y1), 0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 7; i++) dl[i] = 0;
    vprev[0] = 1'b0;
    vprev[1] = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    strobe_in(65536, 0);
    idle(6);
    check("fresh_after_rst", int'(y0), -1061);

    // Saturation in both directions on the large-coefficient instance.
    run_b2b(131071, 8);
    check("sat_pos", int'(y1), 131071);
    run_b2b(-131072, 8);
    check("sat_neg", int'(y1), -131072);

    idle(8);
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
